// File: rtl/dormancy_trigger.sv
// Neglect monitor: counts prescaled ticks without a stimulus rising edge while the plant is active
// and raises a held collapse request. Optional DORMANCY_TRIGGER_CANCEL_EN lets a stimulus edge withdraw a pending request.
module dormancy_trigger #(
  parameter int unsigned NEGLECT_LIMIT = 20,
  parameter int unsigned COUNTER_WIDTH = 8,
  parameter int unsigned TICK_DIV      = 1000,
  parameter int unsigned TICK_WIDTH    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stimulus,
  input  logic [1:0]               state,
  output logic                     collapse_req,
  output logic [COUNTER_WIDTH-1:0] neglect_level
);

  typedef enum logic [1:0] {
    WATCH   = 2'd0,
    REQUEST = 2'd1,
    DORMANT = 2'd2
  } fsm_t;

  localparam logic [1:0]               PLANT_DORMANT = 2'd2;
  localparam logic [TICK_WIDTH-1:0]    TICK_LAST     = TICK_WIDTH'(TICK_DIV - 1);
  localparam logic [COUNTER_WIDTH-1:0] LEVEL_MAX     = '1;
  localparam logic [COUNTER_WIDTH-1:0] LEVEL_LIMIT   = COUNTER_WIDTH'(NEGLECT_LIMIT);

  fsm_t                  fsm;
  logic                  stim_d;
  logic [TICK_WIDTH-1:0] prescaler;

  logic stim_edge_c;
  logic tick_c;
  logic plant_dormant_c;

  assign stim_edge_c     = stimulus & ~stim_d;
  assign tick_c          = (prescaler == TICK_LAST);
  assign plant_dormant_c = (state == PLANT_DORMANT);

  // collapse_req is written alongside every FSM transition so it always equals (fsm == REQUEST)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm           <= WATCH;
      stim_d        <= 1'b0;
      prescaler     <= '0;
      neglect_level <= '0;
      collapse_req  <= 1'b0;
    end else begin
      stim_d <= stimulus;
      case (fsm)
        WATCH: begin
          if (plant_dormant_c) begin
            fsm           <= DORMANT;
            prescaler     <= '0;
            neglect_level <= '0;
            collapse_req  <= 1'b0;
          end else begin
            if (stim_edge_c) begin
              prescaler     <= '0;
              neglect_level <= '0;
            end else begin
              prescaler <= tick_c ? '0 : prescaler + TICK_WIDTH'(1);
              if (tick_c && (neglect_level != LEVEL_MAX))
                neglect_level <= neglect_level + COUNTER_WIDTH'(1);
            end
            // Decision uses the registered level, giving one cycle of request latency
            if (neglect_level >= LEVEL_LIMIT) begin
              fsm          <= REQUEST;
              collapse_req <= 1'b1;
            end
          end
        end

        REQUEST: begin
          if (plant_dormant_c) begin
            fsm           <= DORMANT;
            prescaler     <= '0;
            neglect_level <= '0;
            collapse_req  <= 1'b0;
          end
`ifdef DORMANCY_TRIGGER_CANCEL_EN
          else if (stim_edge_c) begin
            fsm           <= WATCH;
            prescaler     <= '0;
            neglect_level <= '0;
            collapse_req  <= 1'b0;
          end
`endif
        end

        DORMANT: begin
          prescaler     <= '0;
          neglect_level <= '0;
          collapse_req  <= 1'b0;
          if (!plant_dormant_c)
            fsm <= WATCH;
        end

        default: begin
          fsm           <= WATCH;
          prescaler     <= '0;
          neglect_level <= '0;
          collapse_req  <= 1'b0;
        end
      endcase
    end
  end

endmodule
